// File: rtl/systolic_feed_ctrl_if.sv
// Activation-feed port bundle: start/abort command, buffer read port, loader-side vector and status.
// The slave side belongs to systolic_feed_ctrl; the master side to the scheduler/buffer/loader environment.
interface systolic_feed_ctrl_if #(
    parameter int PE_ROW   = 8,
    parameter int BIT_DATA = 8,
    parameter int ADDR_W   = 10,
    parameter int CNT_W    = 16
);
    logic                         i_Start;
    logic                         i_Abort;
    logic [ADDR_W-1:0]            i_Base_Addr;
    logic [CNT_W-1:0]             i_Num_Vec;
    logic                         o_Rd_En;
    logic [ADDR_W-1:0]            o_Rd_Addr;
    logic [PE_ROW*BIT_DATA-1:0]   i_Buf_Data;
    logic [PE_ROW*BIT_DATA-1:0]   o_Data_I;
    logic                         o_Data_Valid;
    logic [PE_ROW-1:0]            o_Row_Valid;
    logic                         o_Busy;
    logic                         o_Done;

    modport slave (
        input  i_Start, i_Abort, i_Base_Addr, i_Num_Vec, i_Buf_Data,
        output o_Rd_En, o_Rd_Addr, o_Data_I, o_Data_Valid, o_Row_Valid, o_Busy, o_Done
    );

    modport master (
        output i_Start, i_Abort, i_Base_Addr, i_Num_Vec, i_Buf_Data,
        input  o_Rd_En, o_Rd_Addr, o_Data_I, o_Data_Valid, o_Row_Valid, o_Busy, o_Done
    );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// Streams K activation vectors (1/cycle, data 1 cycle after read) to the skew loader, then drains PE_ROW+PE_COL cycles and pulses done.
// No backpressure: the buffer and loader always accept; only i_Abort interrupts a run.
module systolic_feed_ctrl #(
    parameter int PE_ROW   = 8,
    parameter int PE_COL   = 8,
    parameter int BIT_DATA = 8,
    parameter int ADDR_W   = 10,
    parameter int CNT_W    = 16
) (
    input  logic                CLK,
    input  logic                RSTN,
    systolic_feed_ctrl_if.slave bus
);
    localparam int DRAIN_LEN = PE_ROW + PE_COL - 1;
    localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q;
    logic [CNT_W-1:0]   rem_q;
    logic [DRAIN_W-1:0] drain_q;
    logic               valid_q;
    logic [PE_ROW-2:0]  skew_q;
    logic [PE_ROW-1:0]  row_vld;
    logic               start_ok;
    logic               last_rd;
    logic               rd_en;
    logic               busy;
    logic               done;

    assign start_ok = (state_q == S_IDLE) && bus.i_Start && !bus.i_Abort
                      && (bus.i_Num_Vec != '0);
    assign last_rd  = (rem_q == CNT_W'(1));
    assign row_vld  = {skew_q, valid_q};

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.i_Start) begin
                    state_d = (bus.i_Num_Vec == '0) ? S_DONE : S_FEED;
                end
            end
            S_FEED:  if (last_rd) state_d = S_DRAIN;
            S_DRAIN: if (drain_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort overrides everything, including a start sampled in IDLE.
        if (bus.i_Abort) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        rd_en = 1'b0;
        busy  = 1'b1;
        done  = 1'b0;
        unique case (state_q)
            S_IDLE:  busy  = 1'b0;
            S_FEED:  rd_en = 1'b1;
            S_DRAIN: ;
            S_DONE:  done  = 1'b1;
            default: busy  = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            addr_q  <= '0;
            rem_q   <= '0;
            drain_q <= '0;
            valid_q <= 1'b0;
            skew_q  <= '0;
        end else begin
            // The wavefront pipeline runs in every state so the tail drains naturally.
            if (bus.i_Abort) begin
                valid_q <= 1'b0;
                skew_q  <= '0;
            end else begin
                valid_q <= rd_en;
                skew_q  <= row_vld[PE_ROW-2:0];
            end

            if (start_ok) begin
                addr_q <= bus.i_Base_Addr;
                rem_q  <= bus.i_Num_Vec;
            end else if (state_q == S_FEED) begin
                addr_q <= addr_q + ADDR_W'(1);
                rem_q  <= rem_q - CNT_W'(1);
                if (last_rd) begin
                    drain_q <= DRAIN_W'(DRAIN_LEN);
                end
            end else if (state_q == S_DRAIN && drain_q != '0) begin
                drain_q <= drain_q - DRAIN_W'(1);
            end
        end
    end

    assign bus.o_Rd_En      = rd_en;
    assign bus.o_Rd_Addr    = addr_q;
    assign bus.o_Data_Valid = valid_q;
    assign bus.o_Data_I     = valid_q ? bus.i_Buf_Data : '0;
    assign bus.o_Row_Valid  = row_vld;
    assign bus.o_Busy       = busy;
    assign bus.o_Done       = done;
endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: per-cycle comparison against a cycle-formula model plus table, corner and random runs.
module tb_systolic_feed_ctrl;
    localparam int PE_ROW   = 8;
    localparam int PE_COL   = 8;
    localparam int BIT_DATA = 8;
    localparam int ADDR_W   = 10;
    localparam int CNT_W    = 16;
    localparam int TAIL     = PE_ROW + PE_COL + 1;

    typedef struct packed {
        logic                       rd_en;
        logic [ADDR_W-1:0]          addr;
        logic                       dv;
        logic [PE_ROW*BIT_DATA-1:0] data;
        logic [PE_ROW-1:0]          rv;
        logic                       busy;
        logic                       done;
    } out_t;

    typedef struct {
        logic [ADDR_W-1:0] base;
        int                k;
        bit                spur;
        int                exp_reads;
        int                exp_done;
        logic [ADDR_W-1:0] exp_last;
        int                exp_rv7_first;
        int                exp_rv7_last;
    } vec_t;

    logic CLK;
    logic RSTN;
    int   n_tests;
    int   n_fail;

    systolic_feed_ctrl_if #(.PE_ROW(PE_ROW), .BIT_DATA(BIT_DATA), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    systolic_feed_ctrl #(
        .PE_ROW(PE_ROW), .PE_COL(PE_COL), .BIT_DATA(BIT_DATA), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [PE_ROW*BIT_DATA-1:0] mem_of(input logic [ADDR_W-1:0] a);
        return (64'(a) * 64'h9E37_79B9_7F4A_7C15) ^ 64'hA5A5_0000_0000_5A5A;
    endfunction

    // Buffer: registered read, junk when not read so zero-gating is exercised.
    initial begin
        bus.i_Buf_Data = '0;
        forever begin
            @(posedge CLK);
            if (bus.o_Rd_En) bus.i_Buf_Data = mem_of(bus.o_Rd_Addr);
            else             bus.i_Buf_Data = {$urandom, $urandom};
        end
    end

    // Expected outputs in cycle n of a run started at edge 0 with count k.
    function automatic out_t model(input int n, input logic [ADDR_W-1:0] base, input int k);
        out_t e;
        e = '0;
        if (k == 0) begin
            e.busy = (n == 1);
            e.done = (n == 1);
            return e;
        end
        e.rd_en = (n >= 1) && (n <= k);
        if (e.rd_en) e.addr = base + ADDR_W'(n - 1);
        e.dv = (n >= 2) && (n <= k + 1);
        if (e.dv) e.data = mem_of(base + ADDR_W'(n - 2));
        for (int r = 0; r < PE_ROW; r++) e.rv[r] = (n >= 2 + r) && (n <= k + 1 + r);
        e.busy = (n >= 1) && (n <= k + TAIL);
        e.done = (n == k + TAIL);
        return e;
    endfunction

    function automatic out_t sample_raw();
        out_t a;
        a.rd_en = bus.o_Rd_En;
        a.addr  = bus.o_Rd_Addr;
        a.dv    = bus.o_Data_Valid;
        a.data  = bus.o_Data_I;
        a.rv    = bus.o_Row_Valid;
        a.busy  = bus.o_Busy;
        a.done  = bus.o_Done;
        return a;
    endfunction

    function automatic out_t sample();
        out_t a;
        a = sample_raw();
        if (!a.rd_en) a.addr = '0;
        return a;
    endfunction

    task automatic chk(input string nm, input int n, input out_t act, input out_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h want %h", nm, n, act, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // Called at a negedge of an IDLE cycle; start is sampled at the next edge (edge 0).
    task automatic run_job(input logic [ADDR_W-1:0] base, input int k, input bit spur, input int abort_at,
                           output int reads, output int dvs, output int dones, output int done_cyc,
                           output logic [ADDR_W-1:0] last_addr, output int rv7_first, output int rv7_last);
        out_t a;
        int   end_n;
        reads = 0; dvs = 0; dones = 0; done_cyc = -1; last_addr = '0; rv7_first = -1; rv7_last = -1;
        bus.i_Base_Addr = base;
        bus.i_Num_Vec   = CNT_W'(k);
        bus.i_Start     = 1'b1;
        bus.i_Abort     = 1'b0;
        end_n = (k == 0) ? 1 : k + TAIL;
        if (abort_at > 0) end_n = abort_at;
        for (int n = 1; n <= end_n; n++) begin
            @(negedge CLK);
            a = sample();
            chk("run", n, a, model(n, base, k));
            if (a.rd_en) begin reads++; last_addr = a.addr; end
            if (a.dv) dvs++;
            if (a.done) begin dones++; done_cyc = n; end
            if (a.rv[PE_ROW-1]) begin
                if (rv7_first < 0) rv7_first = n;
                rv7_last = n;
            end
            bus.i_Start   = spur && (n % 3 == 0) && (n < end_n);
            bus.i_Num_Vec = spur ? CNT_W'($urandom_range(0, 50)) : CNT_W'(k);
            if (abort_at > 0 && n == abort_at) begin
                bus.i_Abort = 1'b1;
                bus.i_Start = 1'b1;
            end
        end
        if (abort_at > 0) begin
            @(negedge CLK);
            bus.i_Abort = 1'b0;
            bus.i_Start = 1'b0;
            chk("after_abort", abort_at + 1, sample(), '0);
        end
    endtask

    vec_t              tbl [5];
    int                reads, dvs, dones, done_cyc, rv7_first, rv7_last;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] rbase;
    int                rk;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        tbl[0] = '{10'h010,   4, 1'b0,   4,  21, 10'h013, 9,  12};
        tbl[1] = '{10'h3FE,   4, 1'b0,   4,  21, 10'h001, 9,  12};
        tbl[2] = '{10'h3FF,   1, 1'b1,   1,  18, 10'h3FF, 9,   9};
        tbl[3] = '{10'h200, 300, 1'b0, 300, 317, 10'h32B, 9, 308};
        tbl[4] = '{10'h0AA,   9, 1'b1,   9,  26, 10'h0B2, 9,  17};

        RSTN = 1'b0;
        bus.i_Start = 1'b0;
        bus.i_Abort = 1'b0;
        bus.i_Base_Addr = '0;
        bus.i_Num_Vec = '0;
        repeat (3) @(negedge CLK);
        chk("reset_state", 0, sample_raw(), '0);
        RSTN = 1'b1;
        @(negedge CLK);
        chk("idle_after_reset", 0, sample_raw(), '0);

        for (int i = 0; i < 5; i++) begin
            run_job(tbl[i].base, tbl[i].k, tbl[i].spur, 0,
                    reads, dvs, dones, done_cyc, last_addr, rv7_first, rv7_last);
            chk_int($sformatf("tbl%0d_reads", i), reads, tbl[i].exp_reads);
            chk_int($sformatf("tbl%0d_dvalid", i), dvs, tbl[i].exp_reads);
            chk_int($sformatf("tbl%0d_done_cycle", i), done_cyc, tbl[i].exp_done);
            chk_int($sformatf("tbl%0d_dones", i), dones, 1);
            chk_int($sformatf("tbl%0d_last_addr", i), int'(last_addr), int'(tbl[i].exp_last));
            chk_int($sformatf("tbl%0d_rv7_first", i), rv7_first, tbl[i].exp_rv7_first);
            chk_int($sformatf("tbl%0d_rv7_last", i), rv7_last, tbl[i].exp_rv7_last);
            @(negedge CLK);
            chk("idle_gap", 0, sample(), '0);
        end

        // Zero count, then a start in the very next IDLE cycle with spurious starts during the run.
        run_job(10'h055, 0, 1'b0, 0, reads, dvs, dones, done_cyc, last_addr, rv7_first, rv7_last);
        chk_int("zero_reads", reads, 0);
        chk_int("zero_done_cycle", done_cyc, 1);
        @(negedge CLK);
        chk("zero_idle", 2, sample(), '0);
        run_job(10'h100, 2, 1'b1, 0, reads, dvs, dones, done_cyc, last_addr, rv7_first, rv7_last);
        chk_int("b2b_reads", reads, 2);
        chk_int("b2b_dones", dones, 1);
        @(negedge CLK);
        chk("b2b_idle", 0, sample(), '0);

        // Abort with a simultaneous start, then a fresh start in the following cycle.
        run_job(10'h020, 10, 1'b0, 6, reads, dvs, dones, done_cyc, last_addr, rv7_first, rv7_last);
        chk_int("abort_reads", reads, 6);
        chk_int("abort_dones", dones, 0);
        run_job(10'h030, 5, 1'b0, 0, reads, dvs, dones, done_cyc, last_addr, rv7_first, rv7_last);
        chk_int("post_abort_reads", reads, 5);
        chk_int("post_abort_done_cycle", done_cyc, 22);
        @(negedge CLK);

        // Asynchronous reset in the middle of a K=20 feed.
        bus.i_Base_Addr = 10'h180;
        bus.i_Num_Vec   = 16'd20;
        bus.i_Start     = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            @(negedge CLK);
            bus.i_Start = 1'b0;
            chk("pre_reset", n, sample(), model(n, 10'h180, 20));
        end
        #1 RSTN = 1'b0;
        #1 chk("async_reset", 5, sample_raw(), '0);
        @(negedge CLK);
        RSTN = 1'b1;
        @(negedge CLK);
        chk("post_reset_idle", 0, sample_raw(), '0);

        for (int i = 0; i < 8; i++) begin
            rbase = ADDR_W'($urandom_range(0, 1023));
            rk    = int'($urandom_range(1, 30));
            run_job(rbase, rk, 1'($urandom_range(0, 1)), 0,
                    reads, dvs, dones, done_cyc, last_addr, rv7_first, rv7_last);
            chk_int($sformatf("rand%0d_dvalid", i), dvs, rk);
            chk_int($sformatf("rand%0d_dones", i), dones, 1);
            @(negedge CLK);
            chk("rand_idle", 0, sample(), '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/systolic_feed_ctrl.md
# systolic_feed_ctrl

Sequencer for the input-activation path of the systolic array. On a start command it streams K input vectors from the activation buffer at one vector per cycle and forwards them, zero-gated, to the row-skew loader. It also generates a per-row skewed valid mask that tracks the loader's diagonal wavefront. It then waits for the array to drain and pulses done. It sits between the activation buffer and the skew loader, under the top-level tile scheduler.

## Interface
- PE_ROW, 8, number of array rows (loader lanes).
- PE_COL, 8, number of array columns (sets drain length).
- BIT_DATA, 8, bits per activation element.
- ADDR_W, 10, activation-buffer address width.
- CNT_W, 16, width of vector-count field.
- CLK  input  1  single clock, rising edge.
- RSTN  input  1  asynchronous, active-low reset.
- i_Start  input  1  single-cycle start request; sampled only in IDLE.
- i_Abort  input  1  synchronous abort; highest priority outside reset.
- i_Base_Addr  input  ADDR_W  first buffer address, captured with i_Start.
- i_Num_Vec  input  CNT_W  number of vectors K, captured with i_Start.
- o_Rd_En  output  1  buffer read strobe.
- o_Rd_Addr  output  ADDR_W  buffer read address.
- i_Buf_Data  input  PE_ROW*BIT_DATA  buffer read data; valid exactly 1 cycle after o_Rd_En.
- o_Data_I  output  PE_ROW*BIT_DATA  unskewed vector to the skew loader; zero when not valid.
- o_Data_Valid  output  1  o_Data_I carries a real vector.
- o_Row_Valid  output  PE_ROW  bit r = o_Data_Valid delayed r cycles (bit 0 undelayed), aligned with loader lane r output.
- o_Busy  output  1  high in any state except IDLE.
- o_Done  output  1  single-cycle completion pulse.

## Operation
- States: IDLE, FEED, DRAIN, DONE.
- IDLE: i_Start=1 with i_Num_Vec>0 → capture base/count, go to FEED. i_Start=1 with i_Num_Vec=0 → go directly to DONE. i_Start in any other state is ignored; no queuing.
- FEED: o_Rd_En=1 every cycle, o_Rd_Addr = base + n for n = 0..K-1. Addition is modulo 2^ADDR_W; wrap from all-ones to 0 is legal. After the K-th read, go to DRAIN with drain counter loaded to PE_ROW+PE_COL-1.
- Data path: valid_q = o_Rd_En registered. o_Data_Valid = valid_q. o_Data_I = valid_q ? i_Buf_Data : 0. This path is combinational from i_Buf_Data, gated by a register.
- o_Row_Valid: bit 0 = valid_q. Bits 1..PE_ROW-1 come from a PE_ROW-1 stage shift register fed by valid_q. The shift register runs in every state.
- DRAIN: counter decrements each cycle. At 0 → DONE. Drain length is PE_ROW+PE_COL cycles: 1 buffer latency + PE_ROW-1 skew + PE_COL column propagation.
- DONE: o_Done=1 for one cycle, then IDLE. Back-to-back start is accepted in the IDLE cycle immediately following.
- i_Abort=1 in any state → IDLE at next edge. o_Rd_En is low in the following cycle. valid_q and the whole row-valid shift register clear at the same edge. No o_Done pulse. i_Abort in IDLE has no effect. i_Abort and i_Start together: abort wins, start is dropped.
- K counting: count register of CNT_W bits; K up to 2^CNT_W-1 must work without overflow.

## Timing
- Reset (RSTN low, async): state IDLE. o_Rd_En=0, o_Rd_Addr=0, o_Data_Valid=0, o_Data_I=0, o_Row_Valid=0, o_Busy=0, o_Done=0. Counters cleared. Reset mid-FEED/DRAIN behaves like abort but takes effect immediately.
- Cycle numbering: the edge that samples i_Start is edge 0; cycle n follows edge n-1.
- o_Busy: high cycles 1 through K+PE_ROW+PE_COL+1, inclusive of the DONE cycle.
- o_Rd_En: cycles 1..K. o_Data_Valid: cycles 2..K+1. o_Row_Valid[r]: cycles 2+r..K+1+r.
- o_Done: cycle K+PE_ROW+PE_COL+1. Zero-count start: o_Done in cycle 1, o_Rd_En never asserted.
- All outputs are registered except o_Data_I, which is a registered-gate AND of buffer data.

## Test plan
- Reset: drive RSTN low asynchronously mid-FEED (K=20, cycle 5) → all outputs 0 within the same cycle. After release, state is IDLE and o_Busy=0.
- Basic run, PE_ROW=8, PE_COL=8, base=0x10, K=4 → o_Rd_En cycles 1-4 with addresses 0x10-0x13. o_Data_Valid cycles 2-5, data matching buffer model. o_Row_Valid[7] cycles 9-12. o_Done only in cycle 21. o_Data_I=0 everywhere else.
- Address wrap, ADDR_W=10, base=0x3FE, K=4 → addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Zero count and back-to-back: i_Num_Vec=0 → o_Done in cycle 1, no reads. Then i_Start with K=2 in the next IDLE cycle → accepted. i_Start pulses during that run's FEED/DRAIN → ignored, with exactly one o_Done.
- Abort: K=10, assert i_Abort in cycle 6 together with i_Start → o_Rd_En low from cycle 7. o_Row_Valid=0 from cycle 7. No o_Done. A new start is accepted in cycle 7.
- Long run, K=300 → exactly 300 reads, o_Data_Valid total 300 cycles. o_Done in cycle 317.
